// File: rtl/i2c_slave_rx.sv
// Write-only I2C slave receiver: address match, ACK/NACK generation and byte output.
module i2c_slave_rx #(
  parameter logic [6:0] OWN_ADDR = 7'h50
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       scl,
  inout  wire        sda,
  input  logic       rx_ready,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       addr_match,
  output logic       busy
);

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned CNT_W  = 4;

  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, DATA, DATA_ACK, WAIT_STOP
  } state_t;

  state_t              state_q, state_d;
  logic                scl_s1_q, scl_s1_d, scl_s2_q, scl_s2_d, scl_p_q, scl_p_d;
  logic                sda_s1_q, sda_s1_d, sda_s2_q, sda_s2_d, sda_p_q, sda_p_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [BYTE_W-1:0]   shift_q, shift_d;
  logic [BYTE_W-1:0]   data_out_q, data_out_d;
  logic                data_valid_q, data_valid_d;
  logic                addr_match_q, addr_match_d;
  logic                busy_q, busy_d;
  logic                sda_oe_q, sda_oe_d;
  logic                ack_ok_q, ack_ok_d;

  logic                scl_rise, scl_fall, start_cond, stop_cond;
  logic [BYTE_W-1:0]   shifted;

  // Open-drain output: only ever pulls low.
  assign sda = sda_oe_q ? 1'b0 : 1'bz;

  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;
  assign addr_match = addr_match_q;
  assign busy       = busy_q;

  // Edge and bus-condition detection on synchronized signals.
  always_comb begin
    scl_rise   = scl_s2_q & ~scl_p_q;
    scl_fall   = ~scl_s2_q & scl_p_q;
    start_cond = scl_s2_q & sda_p_q & ~sda_s2_q;
    stop_cond  = scl_s2_q & ~sda_p_q & sda_s2_q;
    shifted    = {shift_q[BYTE_W-2:0], sda_s2_q};
  end

  // Next-state and output logic.
  always_comb begin
    state_d      = state_q;
    scl_s1_d     = scl;
    scl_s2_d     = scl_s1_q;
    scl_p_d      = scl_s2_q;
    sda_s1_d     = sda;
    sda_s2_d     = sda_s1_q;
    sda_p_d      = sda_s2_q;
    cnt_d        = cnt_q;
    shift_d      = shift_q;
    data_out_d   = data_out_q;
    data_valid_d = 1'b0;
    addr_match_d = addr_match_q;
    busy_d       = busy_q;
    sda_oe_d     = sda_oe_q;
    ack_ok_d     = ack_ok_q;

    if (start_cond) begin
      state_d      = ADDR;
      cnt_d        = '0;
      addr_match_d = 1'b0;
      busy_d       = 1'b1;
      sda_oe_d     = 1'b0;
    end else if (stop_cond) begin
      state_d      = IDLE;
      cnt_d        = '0;
      addr_match_d = 1'b0;
      busy_d       = 1'b0;
      sda_oe_d     = 1'b0;
    end else begin
      case (state_q)
        ADDR, DATA: begin
          if (scl_rise && cnt_q < CNT_W'(BYTE_W)) begin
            shift_d = shifted;
            cnt_d   = cnt_q + CNT_W'(1);
            if (state_q == DATA && cnt_q == CNT_W'(BYTE_W - 1)) begin
              ack_ok_d = rx_ready;
              if (rx_ready) begin
                data_out_d   = shifted;
                data_valid_d = 1'b1;
              end
            end
          end else if (scl_fall && cnt_q == CNT_W'(BYTE_W)) begin
            if (state_q == ADDR) begin
              if (shift_q[7:1] == OWN_ADDR && !shift_q[0]) begin
                state_d      = ADDR_ACK;
                sda_oe_d     = 1'b1;
                addr_match_d = 1'b1;
              end else begin
                state_d = WAIT_STOP;
              end
            end else if (ack_ok_q) begin
              state_d  = DATA_ACK;
              sda_oe_d = 1'b1;
            end else begin
              state_d = WAIT_STOP;
            end
          end
        end
        ADDR_ACK, DATA_ACK: begin
          if (scl_fall) begin
            state_d  = DATA;
            sda_oe_d = 1'b0;
            cnt_d    = '0;
          end
        end
        default: begin
          sda_oe_d = 1'b0;
        end
      endcase
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      scl_s1_q     <= 1'b1;
      scl_s2_q     <= 1'b1;
      scl_p_q      <= 1'b1;
      sda_s1_q     <= 1'b1;
      sda_s2_q     <= 1'b1;
      sda_p_q      <= 1'b1;
      cnt_q        <= '0;
      shift_q      <= '0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      addr_match_q <= 1'b0;
      busy_q       <= 1'b0;
      sda_oe_q     <= 1'b0;
      ack_ok_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      scl_s1_q     <= scl_s1_d;
      scl_s2_q     <= scl_s2_d;
      scl_p_q      <= scl_p_d;
      sda_s1_q     <= sda_s1_d;
      sda_s2_q     <= sda_s2_d;
      sda_p_q      <= sda_p_d;
      cnt_q        <= cnt_d;
      shift_q      <= shift_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      addr_match_q <= addr_match_d;
      busy_q       <= busy_d;
      sda_oe_q     <= sda_oe_d;
      ack_ok_q     <= ack_ok_d;
    end
  end

endmodule

// File: tb/tb_i2c_slave_rx.sv
// Self-checking bench for i2c_slave_rx: directed scenarios plus random write transactions.
module tb_i2c_slave_rx;

  localparam logic [6:0] OWN = 7'h50;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       scl = 1'b1;
  logic       m_sda = 1'b1;
  logic       rx_ready = 1'b1;
  logic [7:0] data_out;
  logic       data_valid, addr_match, busy;
  wire        sda;

  pullup (sda);
  assign sda = m_sda ? 1'bz : 1'b0;

  i2c_slave_rx #(.OWN_ADDR(OWN)) dut (
    .clk(clk), .reset(reset), .scl(scl), .sda(sda), .rx_ready(rx_ready),
    .data_out(data_out), .data_valid(data_valid), .addr_match(addr_match), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int         m_phase;      // 0 expect address, 1 receiving data, 2 ignoring
  bit         m_addressed;
  logic [7:0] exp_q[$];
  logic [7:0] obs_q[$];
  logic [7:0] exp_last = 8'h00;
  int         wide_pulses = 0;
  logic       dv_prev = 1'b0;

  // Record every data_valid pulse and flag pulses longer than one clk.
  always @(negedge clk) begin
    if (data_valid) obs_q.push_back(data_out);
    if (data_valid && dv_prev) wide_pulses++;
    dv_prev = data_valid;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic m_start();
    m_phase = 0;
    m_addressed = 1'b0;
  endtask

  task automatic m_byte(input logic [7:0] b, input bit rdy, output bit ack);
    ack = 1'b0;
    if (m_phase == 0) begin
      ack = (b[7:1] == OWN) && !b[0];
      m_addressed = ack;
      m_phase = ack ? 1 : 2;
    end else if (m_phase == 1) begin
      if (rdy) begin
        ack = 1'b1;
        exp_q.push_back(b);
        exp_last = b;
      end else begin
        m_phase = 2;
      end
    end
  endtask

  // START from either an idle bus or (repeated) with scl low.
  task automatic bus_start();
    if (!scl) begin
      m_sda = 1'b1; clks(4);
      scl = 1'b1;   clks(8);
    end
    m_sda = 1'b0; clks(8);
    scl = 1'b0;   clks(4);
    m_start();
  endtask

  task automatic bus_stop();
    m_sda = 1'b0; clks(4);
    scl = 1'b1;   clks(8);
    m_sda = 1'b1; clks(8);
    m_addressed = 1'b0;
  endtask

  task automatic send_bits(input logic [7:0] b, input int n);
    for (int i = 0; i < n; i++) begin
      m_sda = b[7-i]; clks(4);
      scl = 1'b1;     clks(8);
      scl = 1'b0;     clks(4);
    end
  endtask

  // One byte plus the 9th clock; checks ACK and addr_match against the model.
  task automatic xfer(input string tag, input logic [7:0] b, input bit rdy);
    bit exp_ack;
    logic ack;
    rx_ready = rdy;
    send_bits(b, 8);
    m_sda = 1'b1; clks(4);
    scl = 1'b1;   clks(4);
    ack = (sda === 1'b0);
    clks(4);
    scl = 1'b0;   clks(4);
    m_byte(b, rdy, exp_ack);
    chk({tag, "_ack"}, 32'(ack), 32'(exp_ack));
    chk({tag, "_amatch"}, 32'(addr_match), 32'(m_addressed));
  endtask

  // Compare received bytes against the model after a transaction.
  task automatic check_rx(input string tag);
    chk({tag, "_count"}, 32'(obs_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
      chk({tag, "_byte"}, 32'(obs_q[i]), 32'(exp_q[i]));
    chk({tag, "_dout"}, 32'(data_out), 32'(exp_last));
    exp_q.delete();
    obs_q.delete();
  endtask

  initial begin
    m_start();
    clks(3);
    chk("rst_sda", 32'(sda), 32'(1'b1));
    chk("rst_dout", 32'(data_out), 32'h00);
    chk("rst_dv", 32'(data_valid), 32'(1'b0));
    chk("rst_amatch", 32'(addr_match), 32'(1'b0));
    chk("rst_busy", 32'(busy), 32'(1'b0));
    reset = 1'b0;
    clks(10);
    chk("idle_busy", 32'(busy), 32'(1'b0));

    // Basic write
    bus_start();
    chk("t1_busy", 32'(busy), 32'(1'b1));
    xfer("t1_a", 8'hA0, 1'b1);
    xfer("t1_d", 8'h3C, 1'b1);
    bus_stop();
    chk("t1_busy_stop", 32'(busy), 32'(1'b0));
    chk("t1_amatch_stop", 32'(addr_match), 32'(1'b0));
    check_rx("t1");

    // Wrong address
    bus_start();
    xfer("t2_a", 8'hA2, 1'b1);
    xfer("t2_d", 8'h55, 1'b1);
    bus_stop();
    check_rx("t2");

    // Read request refused; stays busy until STOP
    bus_start();
    xfer("t3_a", 8'hA1, 1'b1);
    xfer("t3_d", 8'h77, 1'b1);
    chk("t3_busy", 32'(busy), 32'(1'b1));
    bus_stop();
    chk("t3_busy_stop", 32'(busy), 32'(1'b0));
    check_rx("t3");

    // Consumer not ready on third byte
    bus_start();
    xfer("t4_a", 8'hA0, 1'b1);
    xfer("t4_d1", 8'h01, 1'b1);
    xfer("t4_d2", 8'h02, 1'b1);
    xfer("t4_d3", 8'h03, 1'b0);
    xfer("t4_d4", 8'h04, 1'b1);
    bus_stop();
    check_rx("t4");

    // Repeated START mid-byte
    bus_start();
    xfer("t5_a", 8'hA0, 1'b1);
    send_bits(8'hC3, 4);
    bus_start();
    chk("t5_amatch_rs", 32'(addr_match), 32'(1'b0));
    xfer("t5_a2", 8'hA0, 1'b1);
    xfer("t5_d", 8'hFF, 1'b1);
    bus_stop();
    check_rx("t5");

    // Reset during the 5th data bit
    bus_start();
    xfer("t6_a", 8'hA0, 1'b1);
    send_bits(8'h5A, 4);
    m_sda = 1'b1; clks(4);
    scl = 1'b1;   clks(2);
    reset = 1'b1;
    #1;
    chk("t6_sda", 32'(sda), 32'(1'b1));
    chk("t6_dout", 32'(data_out), 32'h00);
    chk("t6_dv", 32'(data_valid), 32'(1'b0));
    chk("t6_amatch", 32'(addr_match), 32'(1'b0));
    chk("t6_busy", 32'(busy), 32'(1'b0));
    clks(3);
    reset = 1'b0;
    exp_last = 8'h00;
    exp_q.delete();
    obs_q.delete();
    scl = 1'b0; clks(4);
    send_bits(8'hA5, 3);
    chk("t6_ignore_busy", 32'(busy), 32'(1'b0));
    m_sda = 1'b1; clks(4);
    scl = 1'b1;   clks(8);
    bus_start();
    xfer("t6_a2", 8'hA0, 1'b1);
    xfer("t6_d", 8'h99, 1'b1);
    bus_stop();
    check_rx("t6");

    // Random transactions
    for (int t = 0; t < 16; t++) begin
      logic [7:0] a;
      int nb;
      a = ($urandom_range(0, 2) != 0) ? 8'hA0 : 8'($urandom);
      nb = $urandom_range(1, 4);
      bus_start();
      xfer("rnd_a", a, 1'b1);
      for (int k = 0; k < nb; k++)
        xfer("rnd_d", 8'($urandom), ($urandom_range(0, 4) != 0));
      bus_stop();
      check_rx("rnd");
    end

    chk("dv_width", 32'(wide_pulses), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/i2c_slave_rx.md
I2C_SLAVE_RX -- requirements
Module: i2c_slave_rx

Interface
REQ-001 The block SHALL have parameter OWN_ADDR, default 7'h50, giving the 7-bit slave address it responds to.
REQ-002 The block SHALL have port clk  input  1  system clock; all logic is on its rising edge.
REQ-003 The block SHALL have port reset  input  1  reset, asynchronous, active-high.
REQ-004 The block SHALL have port scl  input  1  I2C clock from the bus master.
REQ-005 The block SHALL have port sda  inout  1  I2C data; the block drives only 0 (ACK), otherwise high-Z.
REQ-006 The block SHALL have port rx_ready  input  1  consumer can accept a byte; sampled at ACK decision.
REQ-007 The block SHALL have port data_out  output  8  last received data byte, MSB first on the bus.
REQ-008 The block SHALL have port data_valid  output  1  one-clk pulse when data_out is updated.
REQ-009 The block SHALL have port addr_match  output  1  high from address ACK until STOP or repeated START.
REQ-010 The block SHALL have port busy  output  1  high between a detected START and the next STOP.

Function
REQ-011 scl and sda SHALL each pass through a 2-flop synchronizer; all edge and condition detection SHALL use the synchronized values and their one-cycle-delayed copies.
REQ-012 START SHALL be a synchronized sda falling edge while synchronized scl is 1; STOP SHALL be an sda rising edge while scl is 1.
REQ-013 The FSM SHALL have states IDLE, ADDR, ADDR_ACK, DATA, DATA_ACK and WAIT_STOP.
REQ-014 START in any state SHALL go to ADDR, clear the bit counter, clear addr_match and set busy; this covers repeated START.
REQ-015 STOP in any state SHALL go to IDLE, release sda, and clear busy and addr_match.
REQ-016 In ADDR and DATA, sda SHALL be shifted into an 8-bit register, MSB first, on each scl rising edge.
REQ-017 The 4-bit bit counter SHALL run 0..8; after the 8th sampled bit the FSM SHALL move to the ACK state on the next scl falling edge.
REQ-018 On the address byte, ACK SHALL be given only if bits[7:1]==OWN_ADDR and bit0 (R/W)==0; the block is write-only.
REQ-019 Otherwise the FSM SHALL go to WAIT_STOP, sda stays released (NACK), and all later bytes are ignored.
REQ-020 On a data byte, ACK SHALL be given if rx_ready==1 at the 8th scl rising edge, otherwise NACK and go to WAIT_STOP.
REQ-021 When ACK is given, sda SHALL be driven 0 from the scl falling edge after bit 8 until the next scl falling edge, then released.
REQ-022 data_out SHALL load the shifted byte, and data_valid SHALL pulse for exactly one clk, in the cycle after the 8th data-bit scl rising edge, only when the byte is ACKed.
REQ-023 After the address ACK the FSM SHALL go to DATA.
REQ-024 After each data ACK the FSM SHALL return to DATA for the next byte; the number of bytes is unlimited.
REQ-025 addr_match SHALL be set on the scl falling edge that starts the address ACK.
REQ-026 A START or STOP arriving mid-byte SHALL discard the partial byte without a data_valid pulse.
REQ-027 sda SHALL never be driven 1 by the block, and SHALL be released in IDLE, ADDR, DATA and WAIT_STOP.

Reset
REQ-028 When reset is asserted the block SHALL immediately enter IDLE and release sda (high-Z).
REQ-029 During reset, data_out=8'h00, data_valid=0, addr_match=0, busy=0, the shift register and bit counter SHALL be 0, and the synchronizer flops SHALL be 1.
REQ-030 Reset mid-transfer SHALL abandon the transfer; after release the block SHALL ignore bus activity until the next START.

Verification
REQ-031 START, then 8'hA0 (addr 0x50, W), then 8'h3C, then STOP, with rx_ready=1 -> ACK at both 9th clocks, data_out=8'h3C, one data_valid pulse, busy falls at STOP.
REQ-032 START, then 8'hA2 (addr 0x51) -> sda high at the 9th clock, addr_match=0, no data_valid for the following byte 8'h55.
REQ-033 START, then 8'hA1 (read request to 0x50) -> NACK, FSM in WAIT_STOP until STOP.
REQ-034 Address ACKed, then bytes 8'h01, 8'h02 and 8'h03 with rx_ready=0 at the third byte -> two data_valid pulses (0x01, 0x02), NACK on 0x03, data_out stays 8'h02.
REQ-035 Repeated START after 4 bits of a data byte, then 8'hA0 and 8'hFF -> partial byte dropped, ACK on the new address, data_out=8'hFF.
REQ-036 reset asserted during the 5th data bit -> sda released within the same cycle, all outputs 0, the next full transaction with 8'hA0 and 8'h99 is received correctly.
